// File: rtl/rram_fwft_fifo_if.sv
// rtl/rram_fwft_fifo_if.sv - push/pop/flag bundle for the RRAM controller FWFT FIFO
interface rram_fwft_fifo_if #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  flush;
    logic                  push_n;
    logic [DATA_WIDTH-1:0] din;
    logic                  full;
    logic                  almost_full;
    logic                  pop_n;
    logic [DATA_WIDTH-1:0] dout;
    logic                  empty;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    // FIFO side
    modport slave (
        input  flush, push_n, din, pop_n,
        output full, almost_full, dout, empty, almost_empty, count, overflow, underflow
    );

    // Producer/consumer side
    modport master (
        output flush, push_n, din, pop_n,
        input  full, almost_full, dout, empty, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/rram_fwft_fifo.sv
// rtl/rram_fwft_fifo.sv - first-word-fall-through synchronous FIFO for RRAM controller queues
module rram_fwft_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic              CLK,
    input  logic              reset,
    rram_fwft_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_pop_acc;
    logic w_push_acc;

    // Flags come only from the registered count, so outputs never depend on push_n/pop_n/din.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // A pop on empty is never taken; a push on full only rides along with a taken pop.
    assign w_pop_acc  = !bus.pop_n && !w_empty;
    assign w_push_acc = !bus.push_n && (!w_full || w_pop_acc);

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= AF_CNT);
    assign bus.almost_empty = (r_count <= AE_CNT);
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
    assign bus.dout         = r_mem[r_rd_ptr];

    // Storage array: cleared by reset, left untouched by flush.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!bus.flush && w_push_acc) begin
            r_mem[r_wr_ptr] <= bus.din;
        end
    end

    // Pointers, occupancy and sticky error flags; flush overrides any request in the same cycle.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_acc && !w_pop_acc) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_acc && !w_push_acc) begin
                r_count <= r_count - 1'b1;
            end
            if (!bus.push_n && w_full && !w_pop_acc) begin
                r_overflow <= 1'b1;
            end
            if (!bus.pop_n && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end
endmodule

// File: doc/rram_fwft_fifo.md
# rram_fwft_fifo

First-word-fall-through synchronous FIFO for the RRAM crossbar controller's queues: instruction, input data and output data. Its pop side drives `rram_controller_fsm` through the `pop_n`/`empty`/`dout` handshake, and its push side accepts the controller's `push_n`/`full`/`din` handshake. Each instance sits directly upstream of the controller (instruction or input data) or directly downstream of it (output data). The head entry is always visible on `dout` while `empty` is low, so the controller can decode it before popping.

## Interface
Parameters:
- DATA_WIDTH, 64, entry width (20 for the instruction instance: INSTR_WIDTH+OPCODE_WIDTH)
- DEPTH, 16, number of entries; power of two, ≥4
- AF_LEVEL, DEPTH-2, `almost_full` asserts when count ≥ AF_LEVEL
- AE_LEVEL, 1, `almost_empty` asserts when count ≤ AE_LEVEL

Ports:
- CLK  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- flush  in  1  synchronous clear, active-high
- push_n  in  1  active-low write request
- din  in  DATA_WIDTH  write data
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AF_LEVEL
- pop_n  in  1  active-low read acknowledge
- dout  out  DATA_WIDTH  head entry; valid while `empty`=0
- empty  out  1  count == 0
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: a push was dropped
- underflow  out  1  sticky: a pop was attempted while empty

## Operation
- Storage: DEPTH×DATA_WIDTH register array, `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0.
- Occupancy is tracked by an explicit `count` register, not by pointer difference.
- push_acc = !push_n && (!full || pop_acc).
  - Write to full is accepted only when paired with an accepted pop in the same cycle.
- pop_acc = !pop_n && !empty.
  - Pops are never accepted on an empty FIFO, even with a simultaneous push.
- On push_acc: mem[wr_ptr] ← din, wr_ptr+1.
- On pop_acc: rd_ptr+1.
- Count update:
  - +1 on push only
  - −1 on pop only
  - unchanged on both or neither
- dout = mem[rd_ptr], a combinational read of registered state.
  - Content while `empty`=1 is the stale/reset entry; consumers ignore it.
- Error flags:
  - !push_n && full && !pop_acc → push dropped, overflow ← 1.
  - !pop_n && empty → underflow ← 1.
  - Both flags are sticky until flush or reset.
- flush=1: pointers, count, overflow and underflow ← 0; memory contents untouched.
  - flush has priority over push and pop in the same cycle; both requests are ignored and no error is flagged.
- All flags are decoded from the registered count only. There is no combinational path from push_n/pop_n/din to any output.

## Timing
- Reset (reset=0, asynchronous): pointers=0, count=0, memory=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, dout=0.
  - Release is sampled on the next rising CLK.
- Write-to-read latency: 1 cycle.
  - A push at edge N into an empty FIFO gives empty=0 and dout=din after edge N.
  - The consumer may pop at edge N+1.
- Pop: the next entry appears on dout immediately after the popping edge.
  - Back-to-back pops every cycle are supported.
  - Sustained throughput is 1 push + 1 pop per cycle.
- Full boundary: with count=DEPTH, push+pop in the same cycle leaves count=DEPTH and full=1, and the new data lands at the old wr_ptr.
- Empty boundary: with count=0, push+pop in the same cycle writes the entry and leaves count=1. The pop is ignored and underflow is set.
- Reset asserted mid-burst: outputs take reset values immediately, without waiting for CLK. Nothing pushed before reset is visible afterwards.

## Test plan
- Reset and fill:
  - Stimulus: assert reset=0 for 2 cycles, release, then push 0x1..0x10 into DEPTH=16.
  - Required: empty=1 and count=0 before the first push; almost_full=1 at count=14; full=1 at count=16.
  - Then pop 16 times. Required: dout sequence 0x1..0x10, then empty=1.
- FWFT latency:
  - Stimulus: push 64'hABCD_ABCD_ABCD_ABCD at edge N into an empty FIFO.
  - Required: empty=0 and dout equal to that word right after edge N, before any pop.
- Simultaneous push/pop:
  - Stimulus: at count=16, push 0xAA with a pop in the same cycle.
  - Required: count stays 16, overflow=0, dout advances to the 2nd entry, and 0xAA is read 16th.
  - Stimulus: at count=0, push with a pop in the same cycle.
  - Required: count=1, underflow=1.
- Error flags:
  - Stimulus: push at full without a pop.
  - Required: entry dropped, count=16, overflow=1, and overflow still 1 after 5 idle cycles.
  - Stimulus: flush.
  - Required: count=0, overflow=0, underflow=0.
- Wrap-around and mid-operation reset:
  - Stimulus: 40 push/pop cycles with random gaps, checked against a queue model.
  - Required: data matches the model across pointer wrap.
  - Stimulus: assert reset=0 at count=7 between clock edges.
  - Required: empty=1, count=0 and dout=0 immediately.
